// File: rtl/hdlc_pkg.sv
// Shared HDLC receive-side definitions: FSM states, default buffer depth and
// Rx_Status bit positions.
package hdlc_pkg;

  localparam int unsigned RX_MAX_FRAME_BYTES = 128;
  localparam int unsigned RX_STATUS_W        = 3;

  // Rx_Status = {FrameErr, Abort, Overflow}
  localparam int unsigned RX_ST_OVF   = 0;
  localparam int unsigned RX_ST_ABORT = 1;
  localparam int unsigned RX_ST_FERR  = 2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_RECV  = 2'd1,
    RX_READY = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_frame_ctrl.sv
// HDLC receive frame controller: gates buffer writes, tracks frame size/status
// and hands complete good frames to the host. Optional FCS strip: RX_FCS_STRIP_EN.
module rx_frame_ctrl
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = RX_MAX_FRAME_BYTES
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic                                 Rx_ValidFrame,
  input  logic                                 Rx_WrBuff,
  input  logic                                 Rx_EoF,
  input  logic                                 Rx_AbortSignal,
  input  logic                                 Rx_FrameError,
  input  logic                                 Rx_FCSen,
  input  logic                                 Rx_Drop,
  input  logic                                 Rx_RdBuff,
  output logic                                 Rx_WrEn,
  output logic [$clog2(MAX_FRAME_BYTES)-1:0]   Rx_WrAddr,
  output logic [$clog2(MAX_FRAME_BYTES)-1:0]   Rx_RdAddr,
  output logic                                 Rx_Ready,
  output logic                                 Rx_Overflow,
  output logic [$clog2(MAX_FRAME_BYTES):0]     Rx_FrameSize,
  output logic [RX_STATUS_W-1:0]               Rx_Status
);

  localparam int unsigned ADDR_W = $clog2(MAX_FRAME_BYTES);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]       size_q, size_d;
  logic [RX_STATUS_W-1:0] status_q, status_d;
  logic                   ready_q, ready_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q;

  logic                   vf_rise;
  logic                   full;
  logic                   ovf_now;
  logic                   strip_en;
  logic [CNT_W-1:0]       frame_size;
  logic                   short_frame;
  logic                   wr_en_c;

`ifdef RX_FCS_STRIP_EN
  assign strip_en = Rx_FCSen;
`else
  logic unused_fcsen;
  assign unused_fcsen = Rx_FCSen;
  assign strip_en     = 1'b0;
`endif

  assign vf_rise     = Rx_ValidFrame & ~valid_q;
  assign full        = (cnt_q == CNT_W'(MAX_FRAME_BYTES));
  assign ovf_now     = ovf_q | (Rx_WrBuff & full);
  assign frame_size  = strip_en ? (cnt_q - CNT_W'(2)) : cnt_q;
  // With stripping, a count below 2 would wrap the size, so test it separately
  assign short_frame = (strip_en && (cnt_q < CNT_W'(2))) || (frame_size == '0);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    size_d    = size_q;
    status_d  = status_q;
    ready_d   = ready_q;
    ovf_d     = ovf_q;
    wr_en_c   = 1'b0;

    unique case (state_q)
      RX_IDLE: begin
        if (vf_rise) begin
          state_d  = RX_RECV;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          status_d = '0;
        end
      end

      RX_RECV: begin
        if (Rx_WrBuff) begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        if (Rx_EoF) begin
          status_d = '0;
          if (Rx_AbortSignal) begin
            status_d[RX_ST_ABORT] = 1'b1;
          end else if (ovf_now) begin
            status_d[RX_ST_OVF] = 1'b1;
          end else if (Rx_FrameError || short_frame) begin
            status_d[RX_ST_FERR] = 1'b1;
          end
          if (status_d != '0) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_READY;
            ready_d   = 1'b1;
            size_d    = frame_size;
            rd_addr_d = '0;
          end
        end
      end

      RX_READY: begin
        if (vf_rise) begin
          state_d  = RX_RECV;
          ready_d  = 1'b0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          status_d = '0;
        end else if (Rx_Drop) begin
          state_d = RX_IDLE;
          ready_d = 1'b0;
        end else if (Rx_RdBuff) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if ({1'b0, rd_addr_q} == (size_q - CNT_W'(1))) begin
            state_d = RX_IDLE;
            ready_d = 1'b0;
          end
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  // State registers; valid_q resets high so a level held through reset is not a rise
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      size_q    <= '0;
      status_q  <= '0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      size_q    <= size_d;
      status_q  <= status_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      valid_q   <= Rx_ValidFrame;
    end
  end

  assign Rx_WrEn      = wr_en_c;
  assign Rx_WrAddr    = cnt_q[ADDR_W-1:0];
  assign Rx_RdAddr    = rd_addr_q;
  assign Rx_Ready     = ready_q;
  assign Rx_Overflow  = ovf_q;
  assign Rx_FrameSize = size_q;
  assign Rx_Status    = status_q;

endmodule
